self_draw: RTL
==============

// Module: self_draw
// PURPOSE
//  Downstream drawing stage for the player ship. Consumes op/x/self_enable from the ship
//  control block and rasterises the ship body plus its fire column into one pixel per clock
//  for the VGA adapter (plot_x/plot_y/colour/plot). Each request produces one complete frame.
//  The frame either draws or erases. busy/done tell the top-level FSM when the frame is complete.
// PARAMETERS
//  SHIP_W     8       ship body width, pixels (even, >=2)
//  SHIP_H     4       ship body height, rows
//  FIRE_H     6       fire column height, rows above the ship (must be <= Y_TOP)
//  Y_TOP      100     top row of ship body
//  SCREEN_W   160     visible width; pixels with x >= SCREEN_W are not plotted
//  SHIP_COL   3'b111  ship colour
//  FIRE_COL   3'b100  fire colour
//  BG_COL     3'b000  background/erase colour
// PORTS
//  clk          in   1  system clock
//  reset_n      in   1  asynchronous active-low reset
//  self_enable  in   1  frame request, sampled only in IDLE
//  op           in   2  00 draw ship, fire off; 10 draw ship+fire; 01 erase all; 11 = 00
//  x            in   8  ship left x
//  plot_x       out  8  pixel x
//  plot_y       out  7  pixel y
//  colour       out  3  pixel colour
//  plot         out  1  pixel write strobe
//  busy         out  1  high while a frame is being emitted
//  done         out  1  one-cycle pulse after last pixel of a frame
// BEHAVIOUR
//  - Reset (async, reset_n=0): state IDLE, all outputs 0, counters 0, latches 0; no done pulse.
//  - States: IDLE -> BODY -> FIRE -> IDLE. All outputs registered.
//  - IDLE: if self_enable=1 on an edge, latch x->x_l and op->op_l, then enter BODY; busy=1 next cycle.
//    Changes to x/op/self_enable while busy have no effect.
//  - BODY: raster scan, cy 0..SHIP_H-1 outer, cx 0..SHIP_W-1 inner. Each pixel is
//    (x_l+cx, Y_TOP+cy). colour = BG_COL if op_l=01, else SHIP_COL.
//  - FIRE: 2-pixel-wide column at x_l+SHIP_W/2-1 and x_l+SHIP_W/2. Rows go from Y_TOP-1
//    up to Y_TOP-FIRE_H; the left pixel is emitted before the right one.
//    colour = FIRE_COL if op_l=10, else BG_COL. Always scanned, so op 00/01 clears stale fire.
//  - N = SHIP_W*SHIP_H + 2*FIRE_H pixels (44 at defaults).
//    Cycle 0 is the accept edge; cycles 1..N carry pixels 0..N-1.
//    At cycle N+1: done=1, busy=0, plot=0, state IDLE.
//  - A request with self_enable still high at cycle N+1 is accepted at that edge.
//    Its first pixel appears at cycle N+2, giving continuous redraw with a one-cycle gap.
//  - X clipping: pixel x is computed 9-bit as {1'b0,x_l}+offset.
//    If the result is >= SCREEN_W, plot=0 that cycle but the scan still advances.
//    plot_x is the low 8 bits. No wrap to the left edge.
//  - plot=0, busy=0 whenever IDLE; plot_x/plot_y/colour hold their last values in IDLE.
// TESTING
//  1 reset; self_enable=1,op=00,x=82 for one cycle -> pixel0 (82,100) col 7 at cycle 1,
//    pixel31 (89,103), pixels 32..43 col 0 from (85,99),(86,99) to (86,94); done at cycle 45.
//  2 op=10,x=82 -> same coordinates; pixels 0..31 col 7, pixels 32..43 col 4; 44 plot strobes.
//  3 op=01,x=40 -> 44 pixels all col 0, first (40,100), last (44,94).
//  4 op=00,x=156 -> pixels with x 160..163 plot=0; x=250 -> all body pixels plot=0;
//    done still at cycle 45.
//  5 self_enable held 1; x changed 82->92 at cycle 10 -> frame 1 entirely at x=82;
//    done at cycle 45; frame 2 starts at (92,100) at cycle 46.
//  6 reset_n=0 at cycle 10 mid-BODY -> plot/busy/done drop to 0 immediately;
//    no done pulse; after release, stays IDLE until next self_enable.

Source files
------------

// File: rtl/self_draw.sv
// Player-ship drawing stage: rasterises the ship body and its fire column,
// one pixel per clock, for the VGA adapter. A frame either draws or erases.
module self_draw #(
    parameter int unsigned SHIP_W   = 8,
    parameter int unsigned SHIP_H   = 4,
    parameter int unsigned FIRE_H   = 6,
    parameter int unsigned Y_TOP    = 100,
    parameter int unsigned SCREEN_W = 160,
    parameter logic [2:0]  SHIP_COL = 3'b111,
    parameter logic [2:0]  FIRE_COL = 3'b100,
    parameter logic [2:0]  BG_COL   = 3'b000
) (
    input  logic       clk,
    input  logic       reset_n,
    input  logic       self_enable,
    input  logic [1:0] op,
    input  logic [7:0] x,
    output logic [7:0] plot_x,
    output logic [6:0] plot_y,
    output logic [2:0] colour,
    output logic       plot,
    output logic       busy,
    output logic       done
);

    localparam int unsigned CNT_W = 8;
    localparam int unsigned PX_W  = 9;
    localparam int unsigned PY_W  = 7;

    localparam logic [1:0] OP_ERASE = 2'b01;
    localparam logic [1:0] OP_FIRE  = 2'b10;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        BODY = 2'd1,
        FIRE = 2'd2
    } state_e;

    state_e            state_q;
    logic [7:0]        x_l_q;
    logic [1:0]        op_l_q;
    logic [CNT_W-1:0]  cx_q;
    logic [CNT_W-1:0]  cy_q;
    logic [7:0]        plot_x_q;
    logic [PY_W-1:0]   plot_y_q;
    logic [2:0]        colour_q;
    logic              plot_q;
    logic              busy_q;
    logic              done_q;

    logic [PX_W-1:0]   px_c;
    logic [PY_W-1:0]   py_c;
    logic [2:0]        col_c;
    logic              on_screen_c;
    logic              row_end_c;
    logic              last_row_c;

    // Pixel currently addressed by the scan counters, plus end-of-row/end-of-phase flags.
    always_comb begin
        px_c       = '0;
        py_c       = '0;
        col_c      = BG_COL;
        row_end_c  = 1'b0;
        last_row_c = 1'b0;
        if (state_q == FIRE) begin
            // Fire column straddles the ship centre; cx selects left/right, cy climbs upward.
            px_c       = {1'b0, x_l_q} + PX_W'(SHIP_W / 2 - 1) + PX_W'(cx_q);
            py_c       = PY_W'(Y_TOP - 1) - PY_W'(cy_q);
            col_c      = (op_l_q == OP_FIRE) ? FIRE_COL : BG_COL;
            row_end_c  = (cx_q == CNT_W'(1));
            last_row_c = (cy_q == CNT_W'(FIRE_H - 1));
        end else begin
            px_c       = {1'b0, x_l_q} + PX_W'(cx_q);
            py_c       = PY_W'(Y_TOP) + PY_W'(cy_q);
            col_c      = (op_l_q == OP_ERASE) ? BG_COL : SHIP_COL;
            row_end_c  = (cx_q == CNT_W'(SHIP_W - 1));
            last_row_c = (cy_q == CNT_W'(SHIP_H - 1));
        end
    end

    // Pixels past the right edge are suppressed rather than wrapped.
    assign on_screen_c = (px_c < PX_W'(SCREEN_W));

    // Frame sequencer: accept in IDLE, scan body then fire, pulse done on return.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q  <= IDLE;
            x_l_q    <= '0;
            op_l_q   <= '0;
            cx_q     <= '0;
            cy_q     <= '0;
            plot_x_q <= '0;
            plot_y_q <= '0;
            colour_q <= '0;
            plot_q   <= 1'b0;
            busy_q   <= 1'b0;
            done_q   <= 1'b0;
        end else begin
            case (state_q)
                IDLE: begin
                    plot_q <= 1'b0;
                    busy_q <= 1'b0;
                    // busy still high here only in the cycle after the final pixel.
                    done_q <= busy_q;
                    if (self_enable) begin
                        x_l_q   <= x;
                        op_l_q  <= op;
                        cx_q    <= '0;
                        cy_q    <= '0;
                        state_q <= BODY;
                    end
                end
                BODY, FIRE: begin
                    plot_x_q <= px_c[7:0];
                    plot_y_q <= py_c;
                    colour_q <= col_c;
                    plot_q   <= on_screen_c;
                    busy_q   <= 1'b1;
                    done_q   <= 1'b0;
                    if (row_end_c) begin
                        cx_q <= '0;
                        if (last_row_c) begin
                            cy_q    <= '0;
                            state_q <= (state_q == BODY) ? FIRE : IDLE;
                        end else begin
                            cy_q <= cy_q + CNT_W'(1);
                        end
                    end else begin
                        cx_q <= cx_q + CNT_W'(1);
                    end
                end
                default: begin
                    state_q <= IDLE;
                    plot_q  <= 1'b0;
                    busy_q  <= 1'b0;
                    done_q  <= 1'b0;
                end
            endcase
        end
    end

    assign plot_x = plot_x_q;
    assign plot_y = plot_y_q;
    assign colour = colour_q;
    assign plot   = plot_q;
    assign busy   = busy_q;
    assign done   = done_q;

endmodule
